// File: rtl/mem_arbiter.sv
// Two-requester sequencer for the single-port unified memory. It arbitrates between
// fetch and data accesses and holds each granted access stable until the memory acks it.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ready,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_ready,
  input  logic                    flush,
  output logic                    stall_f,
  output logic                    stall_m,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  // state     | meaning
  // S_IDLE    | no access in flight
  // S_SERVE_I | fetch access in flight
  // S_SERVE_D | data access in flight

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SERVE_I = 2'd1,
    S_SERVE_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_drop;
  logic   w_drop_nxt;
  logic   w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // The port just served is never re-granted from its own ack cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (dm_req)      w_state_nxt = S_SERVE_D;
        else if (if_req) w_state_nxt = S_SERVE_I;
      end
      S_SERVE_I: begin
        if (mem_ack) w_state_nxt = dm_req ? S_SERVE_D : S_IDLE;
      end
      S_SERVE_D: begin
        if (mem_ack) w_state_nxt = if_req ? S_SERVE_I : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_grant = (w_state_nxt != S_IDLE) && (w_state_nxt != r_state);

  always_comb begin
    w_drop_nxt = 1'b0;
    if (w_grant && (w_state_nxt == S_SERVE_I))
      w_drop_nxt = flush;
    else if ((r_state == S_SERVE_I) && (w_state_nxt == S_SERVE_I))
      w_drop_nxt = r_drop | flush;
  end

  always_comb begin
    mem_req  = (r_state != S_IDLE);
    if_ready = mem_ack & (r_state == S_SERVE_I) & ~r_drop & ~flush;
    dm_ready = mem_ack & (r_state == S_SERVE_D);
    if_rdata = mem_rdata;
    dm_rdata = mem_rdata;
    stall_f  = if_req & ~if_ready;
    stall_m  = dm_req & ~dm_ready;
  end

  // Access fields are captured only on a grant and stay frozen for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (w_grant) begin
      if (w_state_nxt == S_SERVE_D) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_we ? dm_be : {BE_WIDTH{1'b1}};
      end else begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= {BE_WIDTH{1'b1}};
      end
    end
  end

  ack_only_while_req: assert property (@(posedge clk) disable iff (!rst_n) mem_ack |-> mem_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked against a transaction-level ownership model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, dm_we, flush, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [BW-1:0] dm_be;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic          if_ready, dm_ready, stall_f, stall_m, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .flush(flush),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Model: who owns the memory (0 none, 1 fetch, 2 data) and the access it owns.
  int            m_own;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [BW-1:0] m_be;
  bit            m_drop;
  int            m_cnt;
  bit            e_if_rdy, e_dm_rdy;
  int            total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_drop = 0; m_cnt = 0;
    m_addr = '0; m_wdata = '0; m_we = 0; m_be = '0;
  endtask

  task automatic check_cycle();
    #1;
    e_if_rdy = mem_ack && (m_own == 1) && !m_drop && !flush;
    e_dm_rdy = mem_ack && (m_own == 2);
    chk("mem_req",  32'(mem_req),  32'(m_own != 0));
    chk("if_ready", 32'(if_ready), 32'(e_if_rdy));
    chk("dm_ready", 32'(dm_ready), 32'(e_dm_rdy));
    chk("stall_f",  32'(stall_f),  32'(if_req && !e_if_rdy));
    chk("stall_m",  32'(stall_m),  32'(dm_req && !e_dm_rdy));
    chk("if_rdata", if_rdata, mem_rdata);
    chk("dm_rdata", dm_rdata, mem_rdata);
    if (m_own != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we",   32'(mem_we), 32'(m_we));
      chk("mem_be",   32'(mem_be), 32'(m_be));
      if (m_own == 2 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic tick();
    int nxt;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (m_own == 0 || mem_ack) begin
      if (m_own == 0)      nxt = dm_req ? 2 : (if_req ? 1 : 0);
      else if (m_own == 1) nxt = dm_req ? 2 : 0;
      else                 nxt = if_req ? 1 : 0;
      if (nxt == 2) begin
        m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
        m_be = dm_we ? dm_be : '1;
      end else if (nxt == 1) begin
        m_addr = if_addr; m_we = 1'b0; m_be = '1;
      end
      m_own  = nxt;
      m_drop = (nxt == 1) && flush;
      m_cnt  = int'($urandom_range(1, 4));
    end else begin
      if (m_own == 1 && flush) m_drop = 1;
      m_cnt--;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    if_req = 0; dm_req = 0; flush = 0; mem_ack = 0; dm_we = 0;
  endtask

  initial begin
    total = 0; bad = 0;
    e_if_rdy = 0; e_dm_rdy = 0;
    model_reset();
    quiet();
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_rdata = 32'hA5A5_0001;
    rst_n = 0;
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be",  32'(mem_be),  32'd0);
    @(negedge clk);
    rst_n = 1;
    check_cycle(); tick();

    // single load, ack three cycles after mem_req rises
    dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_be = 4'h0;
    check_cycle(); chk("ld_stall_c0", 32'(stall_m), 32'd1); tick();
    check_cycle(); chk("ld_addr", mem_addr, 32'h100); chk("ld_be", 32'(mem_be), 32'hF); tick();
    check_cycle(); chk("ld_stall_c2", 32'(stall_m), 32'd1); tick();
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    check_cycle(); chk("ld_ready", 32'(dm_ready), 32'd1); chk("ld_rdata", dm_rdata, 32'h1234_5678); tick();
    quiet();
    check_cycle(); chk("ld_idle", 32'(mem_req), 32'd0); tick();

    // simultaneous requests with single-cycle memory: data first, then fetch
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    check_cycle(); tick();
    mem_ack = 1;
    check_cycle(); chk("sim_dm_rdy", 32'(dm_ready), 32'd1); chk("sim_addr_d", mem_addr, 32'h20); tick();
    dm_req = 0;
    check_cycle(); chk("sim_if_rdy", 32'(if_ready), 32'd1); chk("sim_addr_i", mem_addr, 32'h10);
    chk("sim_req_cont", 32'(mem_req), 32'd1); tick();
    quiet();
    check_cycle(); chk("sim_idle", 32'(mem_req), 32'd0); tick();

    // store with partial byte enables; requester fields move mid-access
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
    check_cycle(); tick();
    dm_addr = 32'h300; dm_wdata = 32'h0BAD_F00D;
    check_cycle(); chk("st_addr", mem_addr, 32'h200); chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_we", 32'(mem_we), 32'd1); chk("st_be", 32'(mem_be), 32'h3); tick();
    mem_ack = 1;
    check_cycle(); chk("st_addr_ack", mem_addr, 32'h200); chk("st_rdy", 32'(dm_ready), 32'd1); tick();
    quiet(); check_cycle(); tick();

    // flush during a four-cycle fetch, then a fresh fetch completes normally
    if_req = 1; if_addr = 32'h40;
    check_cycle(); tick();
    flush = 1;
    check_cycle(); chk("fl_rdy_c1", 32'(if_ready), 32'd0); tick();
    flush = 0; if_addr = 32'h80;
    check_cycle(); tick();
    check_cycle(); tick();
    mem_ack = 1;
    check_cycle(); chk("fl_rdy_ack", 32'(if_ready), 32'd0); chk("fl_addr", mem_addr, 32'h40); tick();
    mem_ack = 0;
    check_cycle(); chk("fl_gap", 32'(mem_req), 32'd0); tick();
    mem_ack = 1;
    check_cycle(); chk("fl_new_rdy", 32'(if_ready), 32'd1); chk("fl_new_addr", mem_addr, 32'h80); tick();
    quiet(); check_cycle(); tick();

    // flush in the fetch ack cycle with a data request waiting
    if_req = 1; if_addr = 32'h44;
    check_cycle(); tick();
    dm_req = 1; dm_we = 0; dm_addr = 32'h500; flush = 1; mem_ack = 1;
    check_cycle(); chk("fa_if_rdy", 32'(if_ready), 32'd0); chk("fa_stall_f", 32'(stall_f), 32'd1); tick();
    if_req = 0; flush = 0;
    check_cycle(); chk("fa_addr", mem_addr, 32'h500); chk("fa_dm_rdy", 32'(dm_ready), 32'd1); tick();
    quiet(); check_cycle(); tick();

    // asynchronous reset in the middle of a store
    dm_req = 1; dm_we = 1; dm_addr = 32'h600; dm_wdata = 32'h55; dm_be = 4'hF;
    check_cycle(); tick();
    mem_ack = 1;
    #2 rst_n = 0;
    #1;
    chk("rs_mem_req", 32'(mem_req), 32'd0);
    chk("rs_dm_rdy", 32'(dm_ready), 32'd0);
    chk("rs_mem_we", 32'(mem_we), 32'd0);
    quiet();
    tick();
    rst_n = 1;
    check_cycle(); tick();
    dm_req = 1; dm_we = 0; dm_addr = 32'h700;
    check_cycle(); tick();
    mem_ack = 1;
    check_cycle(); chk("rs_after_rdy", 32'(dm_ready), 32'd1); chk("rs_after_addr", mem_addr, 32'h700); tick();
    quiet(); check_cycle(); tick();

    // randomized traffic against the ownership model
    e_if_rdy = 0; e_dm_rdy = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_req && e_if_rdy) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      flush = ($urandom_range(0, 9) == 0);
      if (flush && if_req) if_addr = $urandom;
      if ((dm_req && e_dm_rdy) || (!dm_req && $urandom_range(0, 2) == 0)) begin
        dm_req = (dm_req && e_dm_rdy) ? 1'($urandom_range(0, 1)) : 1'b1;
        dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
        dm_be = 4'($urandom_range(0, 15));
      end else if (dm_req && $urandom_range(0, 9) == 0) begin
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_ack = (m_own != 0) && (m_cnt == 1);
      mem_rdata = $urandom;
      check_cycle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer for the core's single-port unified memory. It shares the memory between the fetch stage (instruction reads) and the memory stage (data loads/stores), holding each in-flight access stable until the memory acknowledges it. It produces per-stage stall requests for the pipeline hazard logic and drops fetch responses cancelled by a taken-branch flush. It sits between the pipeline's fetch/memory stages and the memory port.

## Interface
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of data buses; byte-enable width is DATA_WIDTH/8

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch stage requests an instruction read; held until if_ready
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  instruction word; valid when if_ready=1
- if_ready  out  1  fetch access complete
- dm_req  in  1  memory stage requests an access; held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_be  in  DATA_WIDTH/8  store byte enables
- dm_rdata  out  DATA_WIDTH  load data; valid when dm_ready=1
- dm_ready  out  1  data access complete
- flush  in  1  taken-branch flush; cancels an in-flight fetch
- stall_f  out  1  fetch stage stall request to hazard logic
- stall_m  out  1  memory stage stall request to hazard logic
- mem_req  out  1  access request to memory; held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_WIDTH  access address
- mem_wdata  out  DATA_WIDTH  write data
- mem_be  out  DATA_WIDTH/8  byte enables; all ones for reads
- mem_rdata  in  DATA_WIDTH  read data; valid with mem_ack
- mem_ack  in  1  access complete, any latency ≥1 cycle after mem_req rises

## Operation
- FSM states:
  - IDLE: no access in flight.
  - SERVE_I: fetch access in flight.
  - SERVE_D: data access in flight.
- mem_req = (state != IDLE). It is decoded from the state register.
- In IDLE, if dm_req=1 the next state is SERVE_D. Otherwise, if if_req=1 the next state is SERVE_I. Otherwise the FSM stays in IDLE. Data has priority from IDLE.
- On grant, the granted port's fields are registered into mem_addr/mem_we/mem_wdata/mem_be:
  - Fetch grants use mem_we=0 and mem_be=all ones.
  - Data loads also force mem_be to all ones.
  - These registers stay frozen until the state is left. Later requester changes do not affect the in-flight access.
- On mem_ack in SERVE_x:
  - The same-cycle ready output is combinational: if_ready = mem_ack & SERVE_I & ~drop; dm_ready = mem_ack & SERVE_D.
  - if_rdata and dm_rdata pass mem_rdata through.
  - Next state: if the other port's req=1, grant it directly with no IDLE cycle. Otherwise go to IDLE. The just-served port is never re-granted directly from the ack cycle.
- drop flag:
  - Set when flush=1 in SERVE_I, or when flush=1 in the cycle SERVE_I is entered.
  - A flush in the ack cycle suppresses if_ready in that same cycle.
  - Cleared when SERVE_I is left.
  - The dropped access still completes on the memory side, because the bus is never abandoned mid-access.
  - flush has no effect in IDLE or SERVE_D.
- stall_f = if_req & ~if_ready. stall_m = dm_req & ~dm_ready. Both are combinational.
- Reset: state=IDLE, drop=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - Outputs at reset: mem_req=0, if_ready=0, dm_ready=0.
  - if_rdata and dm_rdata follow mem_rdata.
  - stall_f and stall_m follow their requests.
  - Reset mid-access drops mem_req immediately (asynchronous) and abandons the access.

## Timing
- Cycle 0: req seen in IDLE. Cycle 1: mem_req=1 with registered fields.
- Earliest mem_ack is cycle 1, so the earliest ready is cycle 1. A single isolated access therefore costs 2 cycles minimum including the IDLE sample.
- Both requesters pending with 1-cycle memory: accesses alternate D, I, D, I… with one access per cycle after the first.
- Ready is a 1-cycle pulse. A requester must change or drop its req at the edge ending the ready cycle.
- mem_req stays high across a direct handoff. Address and fields change at that edge.
- Memory protocol rule (checked by assertion): mem_ack is only sampled while mem_req=1. An ack while idle is ignored.

## Test plan
- Single load, ack 3 cycles after mem_req: dm_req@c0, addr 0x100 → mem_req c1–c3, mem_addr=0x100, mem_be=0xF. dm_ready=1 only at c3 with dm_rdata=mem_rdata. stall_m=1 c0–c2.
- Simultaneous if_req and dm_req with 1-cycle ack → D granted first, then I. mem_req continuous c1–c2. dm_ready@c1, if_ready@c2. No duplicate re-grant of D.
- Store with dm_be=0x3, wdata 0xDEADBEEF; dm_addr changed mid-access → mem_we=1, mem_be=0x3. mem_addr and mem_wdata stay at the originally latched values until ack.
- flush during 4-cycle fetch → mem_req held until ack. if_ready stays 0 throughout. Next if_req (new addr) granted afterwards and returns if_ready normally.
- flush coincident with ack in SERVE_I → if_ready=0 that cycle. A pending dm_req is still granted at the same edge.
- rst_n asserted low mid SERVE_D → mem_req, dm_ready and mem_we drop to 0 asynchronously. After release, the FSM is in IDLE and the first request issues normally.
